// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical memory port between an I-cache and a D-cache.
// Ports: clk/reset_n (async active-low); i_pmem_* I-cache read side; d_pmem_* D-cache
// read/write side; pmem_* physical memory request/response.
// Build option: PMEM_ARB_RR_EN selects round-robin tie-breaking (default: D always wins ties).
module pmem_arbiter #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t state_q, state_d;
  logic read_q, read_d, write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic d_req, grant_d;
  assign d_req = d_pmem_read | d_pmem_write;
`ifdef PMEM_ARB_RR_EN
  // last_d_q set means D was served last, so I wins the next tie
  logic last_d_q, last_d_d;
  assign grant_d = d_req & (~i_pmem_read | ~last_d_q);
  assign last_d_d = (state_q == IDLE && (d_req || i_pmem_read)) ? grant_d : last_d_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_d_q <= 1'b0;
    else last_d_q <= last_d_d;
`else
  assign grant_d = d_req;
`endif
  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE) begin
      if (grant_d) begin
        state_d = SERVE_D;
        read_d  = d_pmem_read & ~d_pmem_write;
        write_d = d_pmem_write;
        addr_d  = d_pmem_address;
        wdata_d = d_pmem_wdata;
      end else if (i_pmem_read) begin
        state_d = SERVE_I;
        read_d  = 1'b1;
        write_d = 1'b0;
        addr_d  = i_pmem_address;
      end
    end else if (pmem_resp) begin
      state_d = IDLE;
      read_d  = 1'b0;
      write_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
endmodule
